// File: rtl/dead_time_monitor.sv
// dead_time_monitor
//   Checks a complementary gate-drive pair at the switch end. It measures every
//   dead-time gap between the two on-phases, counts commutations, flags gaps
//   shorter than a programmable minimum (sticky) and latches shoot-through
//   (both gates on) into a FAULT state that needs an explicit clear.
//
// Ports
//   MClk_i          system clock, all state updates on the rising edge
//   RstN_i          asynchronous active-low reset
//   S_i[1:0]        gate pair, [1]=high side, [0]=low side
//   MinDeadCount_i  minimum legal gap in cycles, 0 disables the violation check
//   FaultClear_i    level; clears DeadViolation, releases FAULT when S_i==00
//   LastDeadTime_o  length of the most recent completed gap
//   MeasValid_o     one-cycle pulse when LastDeadTime_o is updated
//   DeadViolation_o sticky: a completed gap was shorter than the minimum
//   ShootThrough_o  high while in FAULT
//   CommCount_o     completed commutations, wrapping
module dead_time_monitor #(
  parameter int BIT_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 MClk_i,
  input  logic                 RstN_i,
  input  logic [1:0]           S_i,
  input  logic [BIT_WIDTH-1:0] MinDeadCount_i,
  input  logic                 FaultClear_i,
  output logic [BIT_WIDTH-1:0] LastDeadTime_o,
  output logic                 MeasValid_o,
  output logic                 DeadViolation_o,
  output logic                 ShootThrough_o,
  output logic [CNT_WIDTH-1:0] CommCount_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON_HI = 3'd1,
    ON_LO = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] S_OFF = 2'b00;
  localparam logic [1:0] S_LO  = 2'b01;
  localparam logic [1:0] S_HI  = 2'b10;
  localparam logic [1:0] S_ST  = 2'b11;

  state_t               state_q;
  logic [BIT_WIDTH-1:0] cnt_q;      // 00 samples seen in the current gap
  logic                 prev_hi_q;  // side that was on before the gap
  logic [BIT_WIDTH-1:0] ldt_q;
  logic                 mv_q;
  logic                 dv_q;
  logic                 st_q;
  logic [CNT_WIDTH-1:0] cc_q;

  // Side that completes a commutation out of the current gap.
  logic [1:0] opp_s;
  assign opp_s = prev_hi_q ? S_LO : S_HI;

  always_ff @(posedge MClk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_hi_q <= 1'b0;
      ldt_q     <= '0;
      mv_q      <= 1'b0;
      dv_q      <= 1'b0;
      st_q      <= 1'b0;
      cc_q      <= '0;
    end else begin
      mv_q <= 1'b0;
      // Clear first; a violation completing on this edge overrides below.
      if (FaultClear_i) dv_q <= 1'b0;

      if (S_i == S_ST) begin
        state_q <= FAULT;
        cnt_q   <= '0;
        st_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (S_i == S_HI)      state_q <= ON_HI;
            else if (S_i == S_LO) state_q <= ON_LO;
          end
          ON_HI, ON_LO: begin
            if (S_i == S_OFF) begin
              state_q   <= DEAD;
              cnt_q     <= BIT_WIDTH'(1);
              prev_hi_q <= (state_q == ON_HI);
            end else if ((state_q == ON_HI && S_i == S_LO) ||
                         (state_q == ON_LO && S_i == S_HI)) begin
              // Direct hand-over: a zero-length gap.
              state_q <= (S_i == S_HI) ? ON_HI : ON_LO;
              ldt_q   <= '0;
              mv_q    <= 1'b1;
              cc_q    <= cc_q + CNT_WIDTH'(1);
              if (MinDeadCount_i != '0) dv_q <= 1'b1;
            end
          end
          DEAD: begin
            if (S_i == S_OFF) begin
              if (cnt_q != '1) cnt_q <= cnt_q + BIT_WIDTH'(1);
            end else if (S_i == opp_s) begin
              state_q <= prev_hi_q ? ON_LO : ON_HI;
              ldt_q   <= cnt_q;
              mv_q    <= 1'b1;
              cc_q    <= cc_q + CNT_WIDTH'(1);
              cnt_q   <= '0;
              if (cnt_q < MinDeadCount_i) dv_q <= 1'b1;
            end else begin
              // Same side came back: aborted gap, nothing measured.
              state_q <= prev_hi_q ? ON_HI : ON_LO;
              cnt_q   <= '0;
            end
          end
          FAULT: begin
            cnt_q <= '0;
            if (FaultClear_i && S_i == S_OFF) begin
              state_q <= IDLE;
              st_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign LastDeadTime_o  = ldt_q;
  assign MeasValid_o     = mv_q;
  assign DeadViolation_o = dv_q;
  assign ShootThrough_o  = st_q;
  assign CommCount_o     = cc_q;

endmodule

// File: tb/tb_dead_time_monitor.sv
module tb_dead_time_monitor;
  localparam int BW  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    S = 2'b00;
  logic [BW-1:0] MIN = '0;
  logic          FC = 1'b0;
  logic [BW-1:0] ldt;
  logic          mv, dv, st;
  logic [CW-1:0] cc;

  dead_time_monitor #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .MClk_i(clk), .RstN_i(rst_n), .S_i(S), .MinDeadCount_i(MIN),
    .FaultClear_i(FC), .LastDeadTime_o(ldt), .MeasValid_o(mv),
    .DeadViolation_o(dv), .ShootThrough_o(st), .CommCount_o(cc));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { bit mv; bit dv; bit st; int cc; int ldt; } stat_t;
  typedef struct { int ldt; int cc; } meas_t;
  stat_t stq[$];
  meas_t mq[$];

  // Reference model: which side was last on (0 none, 1 hi, 2 lo), how many
  // all-off samples have followed it, and the fault latch.
  int m_side, m_gap, m_cc, m_ldt;
  bit m_fault, m_dv;

  task automatic model_reset();
    m_side = 0; m_gap = 0; m_cc = 0; m_ldt = 0; m_fault = 0; m_dv = 0;
    stq.delete(); mq.delete();
  endtask

  task automatic step(input logic [1:0] s, input bit fc, input int mn);
    bit meas = 0;
    bit ndv;
    int on;
    stat_t e;
    meas_t m;
    S = s; FC = fc; MIN = BW'(mn);
    ndv = fc ? 1'b0 : m_dv;
    if (s == 2'b11) begin
      m_fault = 1; m_side = 0; m_gap = 0;
    end else if (m_fault) begin
      if (fc && s == 2'b00) m_fault = 0;
    end else if (s == 2'b00) begin
      if (m_side != 0) m_gap++;
    end else begin
      on = (s == 2'b10) ? 1 : 2;
      if (m_side != 0 && m_side != on) begin
        meas = 1;
        m_ldt = (m_gap > SAT) ? SAT : m_gap;
      end
      m_side = on; m_gap = 0;
    end
    if (meas) begin
      m_cc = (m_cc + 1) % (1 << CW);
      if (m_ldt < mn) ndv = 1;
      m.ldt = m_ldt; m.cc = m_cc;
      mq.push_back(m);
    end
    m_dv = ndv;
    e.mv = meas; e.dv = m_dv; e.st = m_fault; e.cc = m_cc; e.ldt = m_ldt;
    stq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [1:0] s, input int n, input int mn);
    for (int i = 0; i < n; i++) step(s, 1'b0, mn);
  endtask

  // Monitor: per-cycle status plus a measurement pop on each MeasValid.
  stat_t ev;
  meas_t me;
  always @(posedge clk) begin
    #1;
    if (rst_n && stq.size() > 0) begin
      ev = stq.pop_front();
      chk("MeasValid", int'(mv), int'(ev.mv));
      chk("DeadViolation", int'(dv), int'(ev.dv));
      chk("ShootThrough", int'(st), int'(ev.st));
      chk("CommCount", int'(cc), ev.cc);
      chk("LastDeadTime", int'(ldt), ev.ldt);
      if (mv) begin
        if (mq.size() == 0) chk("unexpected_meas", 1, 0);
        else begin
          me = mq.pop_front();
          chk("meas_LastDeadTime", int'(ldt), me.ldt);
          chk("meas_CommCount", int'(cc), me.cc);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_ldt"}, int'(ldt), 0);
    chk({nm, "_mv"}, int'(mv), 0);
    chk({nm, "_dv"}, int'(dv), 0);
    chk({nm, "_st"}, int'(st), 0);
    chk({nm, "_cc"}, int'(cc), 0);
  endtask

  initial begin
    logic [1:0] cur;
    int mn, r;
    model_reset();
    // Reset held with S=00.
    repeat (5) @(posedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;
    run(2'b00, 3, 0);

    // Measured gaps of 5 and 7 with Min=5.
    run(2'b10, 10, 5); run(2'b00, 5, 5); run(2'b01, 2, 5);
    run(2'b00, 7, 5); run(2'b10, 2, 5);

    // Short gap, sticky violation, clear, then zero gap.
    run(2'b00, 3, 5); run(2'b01, 3, 5);
    step(2'b01, 1'b1, 5);
    run(2'b10, 2, 5); run(2'b01, 2, 5);

    // Same side returns: no measurement.
    step(2'b00, 1'b1, 5);
    run(2'b00, 3, 5); run(2'b01, 2, 5);
    run(2'b00, 4, 5); run(2'b01, 2, 5);

    // Shoot-through, ignored clear, proper clear, restart.
    run(2'b11, 1, 5);
    step(2'b01, 1'b1, 5);
    run(2'b01, 2, 5);
    step(2'b00, 1'b1, 5);
    run(2'b00, 2, 5); run(2'b01, 2, 5); run(2'b10, 2, 5);

    // Saturating gap, then a measurement with Min=0 never violates.
    step(2'b00, 1'b1, 0);
    run(2'b00, 19, 0); run(2'b01, 2, 0);
    run(2'b01, 1, 15); run(2'b10, 1, 15);

    // Reset in the middle of a gap, then a fresh gap measured from 1.
    run(2'b10, 2, 2); run(2'b00, 6, 2);
    rst_n = 1'b0;
    #2;
    chk_zero("midgap_reset");
    rst_n = 1'b1;
    model_reset();
    #1;
    run(2'b10, 3, 2); run(2'b00, 1, 2); run(2'b01, 2, 2);

    // Randomised traffic.
    cur = 2'b00;
    mn = 4;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 75) begin
        r = $urandom_range(0, 99);
        cur = (r < 40) ? 2'b00 : (r < 68) ? 2'b10 : (r < 96) ? 2'b01 : 2'b11;
      end
      if ($urandom_range(0, 49) == 0) mn = $urandom_range(0, SAT);
      step(cur, m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0), mn);
      if (cur == 2'b11) cur = 2'b00;
    end
    run(2'b00, 2, mn);

    chk("meas_queue_drained", mq.size(), 0);
    chk("stat_queue_drained", stq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
